// File: rtl/booth_mul_sequencer_pkg.sv
// booth_pkg: shared FSM states, sizing constants and Booth digit recoding for booth_mul_sequencer.
// BOOTH_RADIX4_EN selects radix-4 sizing (16 steps, 34-bit accumulator).
package booth_pkg;
    localparam int BOOTH_WIDTH = 32;
`ifdef BOOTH_RADIX4_EN
    localparam int BOOTH_ITER = 16;
    localparam int BOOTH_AW = 34;
`else
    localparam int BOOTH_ITER = 32;
    localparam int BOOTH_AW = 33;
`endif
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {D_ZERO, D_PM, D_NM, D_P2M, D_N2M} digit_t;
    // Radix-4 table; radix-2 reuses it by feeding {Q0,Q0,q_m1}, which only yields 0/+M/-M.
    function automatic digit_t booth_digit(input logic [2:0] b);
        return (b == 3'b001 || b == 3'b010) ? D_PM :
               (b == 3'b011) ? D_P2M :
               (b == 3'b100) ? D_N2M :
               (b == 3'b101 || b == 3'b110) ? D_NM : D_ZERO;
    endfunction
endpackage

// File: rtl/booth_mul_sequencer_if.sv
// booth_mul_sequencer_if: start/busy/done handshake with operands and product halves.
interface booth_mul_sequencer_if #(parameter int WIDTH = booth_pkg::BOOTH_WIDTH);
    logic start;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic busy;
    logic done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master(output start, q, m, input busy, done, hi, lo);
    modport slave(input start, q, m, output busy, done, hi, lo);
endinterface

// File: rtl/booth_mul_sequencer_step.sv
// booth_step: one combinational Booth recode/add/arithmetic-shift step.
// BOOTH_RADIX4_EN selects radix-4 (2-bit shift) instead of radix-2 (1-bit shift).
module booth_step
    import booth_pkg::*;
(
    input  logic [BOOTH_AW-1:0]    a,
    input  logic [BOOTH_WIDTH-1:0] q,
    input  logic                   q_m1,
    input  logic [BOOTH_AW-1:0]    m,
    output logic [BOOTH_AW-1:0]    a_next,
    output logic [BOOTH_WIDTH-1:0] q_next,
    output logic                   q_m1_next
);
    digit_t d;
    logic [BOOTH_AW-1:0] addend;
    logic [BOOTH_AW-1:0] sum;
    always_comb begin
`ifdef BOOTH_RADIX4_EN
        d = booth_digit({q[1:0], q_m1});
`else
        d = booth_digit({q[0], q[0], q_m1});
`endif
        addend = (d == D_PM)  ? m :
                 (d == D_NM)  ? -m :
                 (d == D_P2M) ? (m << 1) :
                 (d == D_N2M) ? -(m << 1) : '0;
        sum = a + addend;
`ifdef BOOTH_RADIX4_EN
        {a_next, q_next, q_m1_next} = {{2{sum[BOOTH_AW-1]}}, sum, q[BOOTH_WIDTH-1:1]};
`else
        {a_next, q_next, q_m1_next} = {sum[BOOTH_AW-1], sum, q};
`endif
    end
endmodule

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: multi-cycle signed 32x32 Booth multiplier with start/busy/done handshake.
// BOOTH_RADIX4_EN halves the step count via radix-4 recoding inside booth_step.
module booth_mul_sequencer
    import booth_pkg::*;
(
    input logic clock,
    input logic clear_n,
    booth_mul_sequencer_if.slave bus
);
    state_t state;
    state_t state_next;
    logic [BOOTH_AW-1:0] a;
    logic [BOOTH_AW-1:0] mr;
    logic [BOOTH_AW-1:0] a_n;
    logic [BOOTH_WIDTH-1:0] qr;
    logic [BOOTH_WIDTH-1:0] q_n;
    logic [BOOTH_WIDTH-1:0] hi;
    logic [BOOTH_WIDTH-1:0] lo;
    logic q_m1;
    logic q_m1_n;
    logic [5:0] cnt;
    logic accept;
    logic last;

    assign accept = bus.start && state != RUN;
    assign last = state == RUN && cnt == 6'(BOOTH_ITER - 1);

    booth_step u_step (
        .a(a), .q(qr), .q_m1(q_m1), .m(mr),
        .a_next(a_n), .q_next(q_n), .q_m1_next(q_m1_n)
    );

    always_ff @(posedge clock or negedge clear_n)
        if (!clear_n) state <= IDLE;
        else state <= state_next;

    always_comb
        state_next = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;

    always_comb begin
        bus.busy = state == RUN;
        bus.done = state == DONE;
        bus.hi = hi;
        bus.lo = lo;
    end

    always_ff @(posedge clock or negedge clear_n)
        if (!clear_n) begin
            a <= '0;
            qr <= '0;
            q_m1 <= 1'b0;
            mr <= '0;
            cnt <= '0;
            hi <= '0;
            lo <= '0;
        end else if (accept) begin
            a <= '0;
            qr <= bus.q;
            q_m1 <= 1'b0;
            mr <= {{(BOOTH_AW - BOOTH_WIDTH){bus.m[BOOTH_WIDTH-1]}}, bus.m};
            cnt <= '0;
        end else if (state == RUN) begin
            a <= a_n;
            qr <= q_n;
            q_m1 <= q_m1_n;
            cnt <= cnt + 6'd1;
            // Product is taken from the post-shift value so it lands on the final-step edge.
            if (last) {hi, lo} <= {a_n[BOOTH_WIDTH-1:0], q_n};
        end
endmodule

// File: doc/booth_mul_sequencer.md
# booth_mul_sequencer

Multi-cycle controller that sequences a 32×32 signed radix-2 Booth multiply, one recoding step per clock. It replaces the single-shot combinational multiplier in the CPU datapath's MUL path and presents a start/busy/done handshake to the control unit. The 64-bit product is written to the HI/LO outputs on completion.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported.
- `clock`  in  1  rising-edge clock
- `clear_n`  in  1  asynchronous active-low reset
- `start`  in  1  request a multiply; sampled in IDLE or DONE
- `q`  in  32  multiplier, two's complement; captured on the accepting edge
- `m`  in  32  multiplicand, two's complement; captured on the accepting edge
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse; `hi`/`lo` valid
- `hi`  out  32  product[63:32], held until the next completion
- `lo`  out  32  product[31:0], held until the next completion

## Operation
- States:
  - IDLE: wait for `start`.
  - RUN: perform Booth steps.
  - DONE: present result.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE when the step counter reaches the last iteration.
  - DONE→RUN on `start`; otherwise DONE→IDLE.
- Registers: `A` (33 bits, sign-extended), `Q` (32), `q_m1` (1), `M` (33, sign-extended `m`), `cnt` (6).
- On accept:
  - A=0, Q=q, q_m1=0, M={m[31],m}, cnt=0.
- Each RUN cycle:
  - Inspect {Q[0],q_m1}: 01 → A=A+M; 10 → A=A−M; 00 or 11 → no change.
  - Then arithmetic-shift {A,Q,q_m1} right by 1, replicating A[32].
  - cnt increments.
- A is 33 bits so that m=0x80000000 cannot overflow the accumulator; the product is {A[31:0],Q}.
- On the final step, {hi,lo} are loaded with the post-shift product in the same edge.
- `start` is ignored while in RUN. Operand changes during RUN have no effect.

## Timing
- Reset (asynchronous, any state, including mid-RUN): state=IDLE, busy=0, done=0, hi=0, lo=0, cnt=0, and all working registers=0. The operation in flight is abandoned and no `done` is issued.
- Edge E0: `start` accepted. Edges E1..E32: the 32 steps, with busy=1 throughout.
- At E32: `hi`/`lo` update and state=DONE. `done`=1 for the cycle following E32.
- Latency: 33 edges from the accepting edge to `done` high.
- A `start` sampled in DONE at E33 begins a new operation. Result: throughput of one product per 33 cycles.
- `hi`/`lo` change only at the final-step edge or on reset.

## Configuration
- `BOOTH_RADIX4_EN` defined:
  - Radix-4 recoding on {Q[1],Q[0],q_m1} with digits 0, ±M, ±2M, and a 2-bit arithmetic shift per step.
  - 16 RUN steps, so `done` appears in the cycle after E16 and latency is 17 edges.
  - A is widened to 34 bits to hold ±2M.
- `BOOTH_RADIX4_EN` undefined: radix-2 as described above.
- Handshake, reset values and results are identical in both modes.

## Structure
- Shared package `booth_pkg`:
  - State enum {IDLE, RUN, DONE}.
  - Constants `BOOTH_WIDTH`=32 and `BOOTH_ITER` (32, or 16 with `BOOTH_RADIX4_EN`).
  - Recoding-digit typedef.
- One combinational sub-module `booth_step`: takes {A,Q,q_m1,M} and returns the next {A,Q,q_m1}. It contains the add/subtract and the shift, so the radix choice is confined there.
- The top level holds the FSM, the counter and the output registers.

## Test plan
- q=6, m=7, pulse `start` → busy for 32 cycles; done pulse with hi=0x00000000, lo=0x0000002A.
- q=5, m=0xFFFFFFFD (−3) → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- q=0x80000000, m=0x80000000 → hi=0x40000000, lo=0x00000000. This exercises the 33-bit accumulator.
- q=0x80000000, m=0xFFFFFFFF → hi=0x00000000, lo=0x80000000. Then change q/m and pulse `start` during RUN → result unchanged and no extra done.
- Start 2×3, deassert `clear_n` at cycle 10 of RUN → immediately busy=0, hi=lo=0. After release, start 4×4 → hi=0, lo=0x10, latency exactly 33 edges.
- Back-to-back: `start` held high → done pulses every 33 cycles, each with the correct product. Repeat with `BOOTH_RADIX4_EN` defined → same products, pulses every 17 cycles.
